// File: rtl/hazard_pipe.sv
// E/M/W pipeline registers with bubble insertion on stall, per-stage result
// latency tracking for the hazard unit, and a saturating stall counter.
module hazard_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      D_instr,
    input  logic [31:0]      D_pc,
    input  logic             D_we,
    input  logic [4:0]       D_A3,
    input  logic [1:0]       D_Tnew,
    output logic [31:0]      E_instr,
    output logic [31:0]      M_instr,
    output logic [31:0]      W_instr,
    output logic [31:0]      E_pc,
    output logic [31:0]      M_pc,
    output logic [31:0]      W_pc,
    output logic             E_we,
    output logic             M_we,
    output logic             W_we,
    output logic [4:0]       E_A3,
    output logic [4:0]       M_A3,
    output logic [4:0]       W_A3,
    output logic [1:0]       E_Tnew,
    output logic [1:0]       M_Tnew,
    output logic [1:0]       W_Tnew,
    output logic             E_fwd,
    output logic             M_fwd,
    output logic             W_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    // Remaining latency counts down to zero and then sticks there.
    function automatic logic [1:0] dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    logic d_writes;
    assign d_writes = D_we && (D_A3 != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            E_instr   <= '0;
            E_pc      <= '0;
            E_we      <= 1'b0;
            E_A3      <= '0;
            E_Tnew    <= '0;
            M_instr   <= '0;
            M_pc      <= '0;
            M_we      <= 1'b0;
            M_A3      <= '0;
            M_Tnew    <= '0;
            W_instr   <= '0;
            W_pc      <= '0;
            W_we      <= 1'b0;
            W_A3      <= '0;
            W_Tnew    <= '0;
            stall_cnt <= '0;
        end else begin
            // A bubble keeps D's PC so the stalled slot stays traceable.
            if (stall) begin
                E_instr <= 32'h0000_0000;
                E_pc    <= D_pc;
                E_we    <= 1'b0;
                E_A3    <= '0;
                E_Tnew  <= '0;
            end else begin
                E_instr <= D_instr;
                E_pc    <= D_pc;
                E_we    <= d_writes;
                E_A3    <= d_writes ? D_A3 : 5'd0;
                E_Tnew  <= D_Tnew;
            end

            M_instr <= E_instr;
            M_pc    <= E_pc;
            M_we    <= E_we;
            M_A3    <= E_A3;
            M_Tnew  <= dec(E_Tnew);

            W_instr <= M_instr;
            W_pc    <= M_pc;
            W_we    <= M_we;
            W_A3    <= M_A3;
            W_Tnew  <= dec(M_Tnew);

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign E_fwd = E_we && (E_A3 != 5'd0) && (E_Tnew == 2'd0);
    assign M_fwd = M_we && (M_A3 != 5'd0) && (M_Tnew == 2'd0);
    assign W_fwd = W_we && (W_A3 != 5'd0) && (W_Tnew == 2'd0);

endmodule

// File: doc/hazard_pipe.md
HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 Parameter: CNT_W, 32, width of the stall performance counter.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 stall  input  1  stall request from the stall unit, 1 = hold F/D and bubble E.
REQ-005 D_instr  input  32  instruction currently in D.
REQ-006 D_pc  input  32  PC of D instruction.
REQ-007 D_we  input  1  D instruction writes the GPR file.
REQ-008 D_A3  input  5  destination GPR of D instruction.
REQ-009 D_Tnew  input  2  cycles until the D instruction's result is available, counted from E entry (0..2).
REQ-010 E_instr/M_instr/W_instr  output  32 each  instruction held in E/M/W.
REQ-011 E_pc/M_pc/W_pc  output  32 each  PC held in E/M/W.
REQ-012 E_we/M_we/W_we  output  1 each  register-write flag per stage.
REQ-013 E_A3/M_A3/W_A3  output  5 each  destination GPR per stage.
REQ-014 E_Tnew/M_Tnew/W_Tnew  output  2 each  remaining result latency per stage, fed to the stall unit.
REQ-015 E_fwd/M_fwd/W_fwd  output  1 each  stage result valid for forwarding.
REQ-016 stall_cnt  output  CNT_W  number of stalled cycles since reset.

Function
REQ-017 All stage outputs and stall_cnt SHALL be registered; E/M/W fields update only on rising clk.
REQ-018 When reset=1 and stall=0, E SHALL load D_instr, D_pc, D_we, D_A3, D_Tnew on the edge.
REQ-019 When reset=1 and stall=1, E SHALL load a bubble: instr=0x00000000, pc=D_pc, we=0, A3=0, Tnew=0.
REQ-020 M SHALL load E's instr, pc, we, A3 every edge regardless of stall; M_Tnew SHALL load dec(E_Tnew).
REQ-021 W SHALL load M's instr, pc, we, A3 every edge regardless of stall; W_Tnew SHALL load dec(M_Tnew).
REQ-022 dec(x) SHALL be x-1 for x>0 and 0 for x=0 (saturating, never wraps to 3).
REQ-023 On load into E, if D_we=0 or D_A3=0, E_A3 SHALL be forced to 0 and E_we to 0 (writes to $0 are suppressed).
REQ-024 X_fwd (X in E,M,W) SHALL be combinational: X_we=1 AND X_A3!=0 AND X_Tnew=0.
REQ-025 stall_cnt SHALL increment by 1 on each edge with reset=1 and stall=1, saturating at all-ones (no wrap).
REQ-026 Latency: a D instruction appears in E 1 edge, M 2 edges, W 3 edges after acceptance, with no stall in between.
REQ-027 A stalled instruction remains in D (held externally); it enters E on the first edge with stall=0.
REQ-028 Consecutive stalls SHALL insert one bubble per stalled cycle; M and W keep draining.
REQ-029 D_Tnew values of 3 SHALL be accepted unchanged and decremented per REQ-022 (no clamp on entry).

Reset
REQ-030 On an edge with reset=0, all E/M/W fields SHALL become 0 (instr, pc, we, A3, Tnew) and stall_cnt SHALL become 0, overriding stall.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight instructions within that edge; the first edge after release loads D normally.
REQ-032 After reset, X_fwd outputs SHALL be 0 (we=0).

Verification
REQ-033 Load: D_instr=0x8C010004 (lw $1), D_we=1, D_A3=1, D_Tnew=2, stall=0 -> E_Tnew=2, then M_Tnew=1, then W_Tnew=0 with W_fwd=1; E_fwd=0, M_fwd=0 along the way.
REQ-034 Stall: stall=1 for 2 cycles with lw in E -> two bubbles in E (E_instr=0, E_Tnew=0, E_we=0), lw proceeds to M then W, stall_cnt=2.
REQ-035 $0 write: D_we=1, D_A3=0, D_Tnew=0 -> E_we=0, E_A3=0, E_fwd=0.
REQ-036 ALU result: addu $3 with D_Tnew=1 -> E_Tnew=1, E_fwd=0; next edge M_Tnew=0, M_fwd=1; W_Tnew=0, W_fwd=1.
REQ-037 Reset mid-flight: three valid instrs in E/M/W, reset=0 for one edge with stall=1 -> all stage fields 0, stall_cnt=0.
REQ-038 Saturation: CNT_W=4, stall=1 for 20 cycles -> stall_cnt holds 0xF from cycle 15 onward.
